// File: rtl/kgprisc_pkg.sv
// Shared definitions for the kgprisc front end: fetch FSM states, NOP encoding, default widths.
package kgprisc_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;

    localparam logic [DEF_DATA_W-1:0] NOP_INSTR = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } ifetch_state_e;

    // A memory read is outstanding in these states.
    function automatic logic is_busy(input ifetch_state_e st);
        return (st == WAIT) || (st == DRAIN);
    endfunction

endpackage

// File: rtl/ifetch_out_reg.sv
// Decode-facing output register of the fetch stage: valid flag, instruction and its PC.
module ifetch_out_reg
    import kgprisc_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_instr,
    input  logic [ADDR_W-1:0] i_pc,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_instr,
    output logic [ADDR_W-1:0] o_pc
);

    logic              r_valid;
    logic [DATA_W-1:0] r_instr;
    logic [ADDR_W-1:0] r_pc;

    // Neither control asserted means hold; clear only drops the valid flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_instr <= DATA_W'(NOP_INSTR);
            r_pc    <= '1;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC handshake, single outstanding imem read, held result for decode.
// Define IFETCH_PERF_CNT_EN to add the fetch_cnt / stall_cnt performance counters.
module instr_fetch_stage
    import kgprisc_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              pc_valid,
    output logic              pc_ready,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [DATA_W-1:0] id_instr,
    output logic [ADDR_W-1:0] id_pc
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    ifetch_state_e     r_state;
    ifetch_state_e     w_state_nxt;
    logic              r_imem_req;
    logic              w_imem_req_nxt;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [ADDR_W-1:0] w_imem_addr_nxt;
    logic              w_pc_ready;
    logic              w_handshake;
    logic              w_out_load;
    logic              w_out_clear;

    always_comb begin
        w_pc_ready = 1'b0;
        if (!reset && !flush) begin
            case (r_state)
                IDLE:    w_pc_ready = 1'b1;
                HOLD:    w_pc_ready = id_ready;
                default: w_pc_ready = 1'b0;
            endcase
        end
    end

    assign w_handshake = pc_valid & w_pc_ready;

    // r_imem_addr doubles as the latched fetch address reported on id_pc.
    always_comb begin
        w_state_nxt     = r_state;
        w_imem_req_nxt  = r_imem_req;
        w_imem_addr_nxt = r_imem_addr;
        w_out_load      = 1'b0;
        w_out_clear     = 1'b0;
        case (r_state)
            IDLE: begin
                if (flush) begin
                    w_out_clear = 1'b1;
                end else if (w_handshake) begin
                    w_state_nxt     = WAIT;
                    w_imem_req_nxt  = 1'b1;
                    w_imem_addr_nxt = pc_in;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    w_imem_req_nxt = 1'b0;
                    if (flush) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_out_load  = 1'b1;
                        w_state_nxt = HOLD;
                    end
                end else if (flush) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    w_imem_req_nxt = 1'b0;
                    w_state_nxt    = IDLE;
                end
            end
            HOLD: begin
                if (flush) begin
                    w_out_clear = 1'b1;
                    w_state_nxt = IDLE;
                end else if (id_ready) begin
                    w_out_clear = 1'b1;
                    if (w_handshake) begin
                        w_state_nxt     = WAIT;
                        w_imem_req_nxt  = 1'b1;
                        w_imem_addr_nxt = pc_in;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt    = IDLE;
                w_imem_req_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_imem_req  <= 1'b0;
            r_imem_addr <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_imem_req  <= w_imem_req_nxt;
            r_imem_addr <= w_imem_addr_nxt;
        end
    end

    ifetch_out_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_out_load),
        .i_clear (w_out_clear),
        .i_instr (imem_rdata),
        .i_pc    (r_imem_addr),
        .o_valid (id_valid),
        .o_instr (id_instr),
        .o_pc    (id_pc)
    );

    assign pc_ready  = w_pc_ready;
    assign imem_req  = r_imem_req;
    assign imem_addr = r_imem_addr;

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (id_valid && id_ready) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (is_busy(r_state)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign fetch_cnt = r_fetch_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed vectors plus a transaction-level reference model.
module tb_instr_fetch_stage;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        pc_ready;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    instr_fetch_stage #(
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_in      (pc_in),
        .pc_valid   (pc_valid),
        .pc_ready   (pc_ready),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_instr   (id_instr),
        .id_pc      (id_pc)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .fetch_cnt  (fetch_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding read, a drop flag for flushed reads, one held instruction.
    bit          m_known = 0;
    bit          m_req;
    logic [31:0] m_addr;
    bit          m_drop;
    bit          m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic [31:0] m_fetch;
    logic [31:0] m_stall;

    function automatic logic exp_ready();
        return !reset && !flush && !m_req && (!m_valid || id_ready);
    endfunction

    initial begin
        bit hs;
        forever begin
            @(negedge clk);
            #1;
            if (m_known && !reset) begin
                chk("m_pc_ready", pc_ready, exp_ready());
                chk("m_imem_req", imem_req, m_req);
                chk("m_imem_addr", imem_addr, m_addr);
                chk("m_id_valid", id_valid, m_valid);
                if (m_valid) begin
                    chk("m_id_instr", id_instr, m_instr);
                    chk("m_id_pc", id_pc, m_pc);
                end
`ifdef IFETCH_PERF_CNT_EN
                chk("m_fetch_cnt", fetch_cnt, m_fetch);
                chk("m_stall_cnt", stall_cnt, m_stall);
`endif
            end
            @(posedge clk);
            if (reset) begin
                m_known = 1;
                m_req   = 0;
                m_addr  = '0;
                m_drop  = 0;
                m_valid = 0;
                m_instr = '0;
                m_pc    = '1;
                m_fetch = '0;
                m_stall = '0;
            end else if (m_known) begin
                hs = pc_valid && exp_ready();
                if (m_valid && id_ready) m_fetch = m_fetch + 1;
                if (m_req) m_stall = m_stall + 1;
                if (m_req) begin
                    if (imem_ack) begin
                        m_req = 0;
                        if (!m_drop && !flush) begin
                            m_valid = 1;
                            m_instr = imem_rdata;
                            m_pc    = m_addr;
                        end
                        m_drop = 0;
                    end else if (flush) begin
                        m_drop = 1;
                    end
                end else begin
                    if (flush || id_ready) m_valid = 0;
                    if (hs) begin
                        m_req  = 1;
                        m_addr = pc_in;
                    end
                end
            end
        end
    end

    task automatic do_fetch(input logic [31:0] a, input int unsigned lat, input logic [31:0] d);
        @(negedge clk);
        pc_valid = 1; pc_in = a; id_ready = 0;
        for (int unsigned i = 1; i <= lat; i++) begin
            @(negedge clk);
            pc_valid   = 0;
            imem_ack   = (i == lat);
            imem_rdata = d;
        end
        @(negedge clk);
        imem_ack = 0; id_ready = 1;
        @(negedge clk);
        id_ready = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1; pc_in = '0; pc_valid = 0; flush = 0;
        imem_ack = 0; imem_rdata = '0; id_ready = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        #2;
        chk("rst_pc_ready", pc_ready, 1'b1);
        chk("rst_id_valid", id_valid, 1'b0);
        chk("rst_id_instr", id_instr, 32'h0);
        chk("rst_id_pc", id_pc, 32'hFFFF_FFFF);
        chk("rst_imem_req", imem_req, 1'b0);
        chk("rst_imem_addr", imem_addr, 32'h0);

        // Basic fetch, ack latency 1
        @(negedge clk); pc_valid = 1; pc_in = 32'h10;
        #2 chk("f1_pc_ready", pc_ready, 1'b1);
        @(negedge clk); pc_valid = 0; imem_ack = 1; imem_rdata = 32'h8C22_0004;
        #2 chk("f1_req", imem_req, 1'b1);
        chk("f1_addr", imem_addr, 32'h10);
        @(negedge clk); imem_ack = 0; imem_rdata = 32'hDEAD_BEEF; id_ready = 1;
        #2 chk("f1_id_valid", id_valid, 1'b1);
        chk("f1_id_instr", id_instr, 32'h8C22_0004);
        chk("f1_id_pc", id_pc, 32'h10);
        chk("f1_req_drop", imem_req, 1'b0);
        @(negedge clk); id_ready = 0;
        #2 chk("f1_consumed", id_valid, 1'b0);

        // Ack latency 5 with a competing pc_valid that must not be accepted
        @(negedge clk); pc_valid = 1; pc_in = 32'h20;
        for (int unsigned i = 1; i <= 5; i++) begin
            @(negedge clk);
            pc_valid = 1; pc_in = 32'h99;
            imem_ack = (i == 5); imem_rdata = 32'h0123_4567;
            #2 chk("l5_req", imem_req, 1'b1);
            chk("l5_addr", imem_addr, 32'h20);
            chk("l5_pc_ready", pc_ready, 1'b0);
        end

        // Stall in HOLD, then back-to-back fetch
        @(negedge clk); imem_ack = 0; pc_valid = 1; pc_in = 32'h30; id_ready = 0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #2 chk("hold_valid", id_valid, 1'b1);
            chk("hold_instr", id_instr, 32'h0123_4567);
            chk("hold_pc", id_pc, 32'h20);
            chk("hold_pc_ready", pc_ready, 1'b0);
        end
        @(negedge clk); id_ready = 1;
        #2 chk("b2b_pc_ready", pc_ready, 1'b1);
        @(negedge clk); id_ready = 0; pc_valid = 0; imem_ack = 1; imem_rdata = 32'hCAFE_F00D;
        #2 chk("b2b_req", imem_req, 1'b1);
        chk("b2b_addr", imem_addr, 32'h30);
        chk("b2b_valid_clr", id_valid, 1'b0);
        @(negedge clk); imem_ack = 0; id_ready = 1;
        #2 chk("b2b_id_pc", id_pc, 32'h30);
        chk("b2b_id_instr", id_instr, 32'hCAFE_F00D);
        @(negedge clk); id_ready = 0;

        // Flush during WAIT without ack: DRAIN until ack
        @(negedge clk); pc_valid = 1; pc_in = 32'h40;
        @(negedge clk); pc_valid = 0;
        #2 chk("dr_issue", imem_req, 1'b1);
        @(negedge clk); flush = 1;
        #2 chk("dr_flush_ready", pc_ready, 1'b0);
        @(negedge clk); flush = 0;
        #2 chk("dr_req_a", imem_req, 1'b1);
        @(negedge clk);
        #2 chk("dr_req_b", imem_req, 1'b1);
        chk("dr_ready_b", pc_ready, 1'b0);
        @(negedge clk); imem_ack = 1; imem_rdata = 32'h00BA_DBAD;
        #2 chk("dr_req_c", imem_req, 1'b1);
        @(negedge clk); imem_ack = 0;
        #2 chk("dr_done_req", imem_req, 1'b0);
        chk("dr_done_valid", id_valid, 1'b0);
        chk("dr_done_ready", pc_ready, 1'b1);

        // Reset mid-WAIT, then a stray ack
        @(negedge clk); pc_valid = 1; pc_in = 32'h50;
        @(negedge clk); pc_valid = 0;
        #2 chk("rw_req", imem_req, 1'b1);
        @(negedge clk); reset = 1;
        @(negedge clk); reset = 0; imem_ack = 1; imem_rdata = 32'h1111_1111;
        #2 chk("rw_req_clr", imem_req, 1'b0);
        @(negedge clk); imem_ack = 0;
        #2 chk("rw_valid", id_valid, 1'b0);
        chk("rw_id_pc", id_pc, 32'hFFFF_FFFF);
        chk("rw_ready", pc_ready, 1'b1);

        // Flush coinciding with ack in WAIT
        @(negedge clk); pc_valid = 1; pc_in = 32'h60;
        @(negedge clk); pc_valid = 0; flush = 1; imem_ack = 1; imem_rdata = 32'h2222_2222;
        @(negedge clk); flush = 0; imem_ack = 0;
        #2 chk("fa_valid", id_valid, 1'b0);
        chk("fa_req", imem_req, 1'b0);

        // Flush in HOLD beats a pending handshake
        @(negedge clk); pc_valid = 1; pc_in = 32'h70;
        @(negedge clk); pc_valid = 0; imem_ack = 1; imem_rdata = 32'h3333_3333;
        @(negedge clk); imem_ack = 0; flush = 1; pc_valid = 1; pc_in = 32'h80; id_ready = 1;
        #2 chk("fh_ready", pc_ready, 1'b0);
        @(negedge clk); flush = 0; pc_valid = 0; id_ready = 0;
        #2 chk("fh_valid", id_valid, 1'b0);
        chk("fh_req", imem_req, 1'b0);

        // Stray ack in IDLE is ignored
        @(negedge clk); imem_ack = 1; imem_rdata = 32'h4444_4444;
        @(negedge clk); imem_ack = 0;
        #2 chk("ia_valid", id_valid, 1'b0);

`ifdef IFETCH_PERF_CNT_EN
        @(negedge clk); reset = 1;
        @(negedge clk); reset = 0;
        do_fetch(32'h100, 2, 32'hA000_0001);
        do_fetch(32'h101, 2, 32'hA000_0002);
        do_fetch(32'h102, 2, 32'hA000_0003);
        #2 chk("cnt_fetch", fetch_cnt, 32'd3);
        chk("cnt_stall", stall_cnt, 32'd6);
`else
        do_fetch(32'h100, 2, 32'hA000_0001);
        #2 chk("df_valid", id_valid, 1'b0);
`endif

        @(negedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
